// File: rtl/if_pkg.sv
// Shared constants and helpers for the instruction-fetch prefetch stage.
package if_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_INSTR_W  = 32;
    localparam int unsigned DEF_DEPTH    = 4;
    localparam int unsigned DEF_STEP     = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0;

    // Ceiling log2, never less than 1; used to size counters that must hold 0..DEPTH.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO holding fetched instructions; flush has priority.
module if_fifo
    import if_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_INSTR_W,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    // Next-state: flush empties, otherwise write at wptr and/or advance rptr.
    always_comb begin
        mem_d   = mem_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        push_ok = push && (count_q != CNT_W'(DEPTH));
        pop_ok  = pop && (count_q != '0);
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wptr_q] = din;
                wptr_d        = wptr_q + AW'(1);
            end
            if (pop_ok) rptr_d = rptr_q + AW'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage cleared on reset so the head reads zero until first fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rptr_q];

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction prefetch: keeps up to DEPTH fetches in flight/buffered, handles
// redirects by discarding every response that was already requested.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter int unsigned        INSTR_W  = DEF_INSTR_W,
    parameter int unsigned        DEPTH    = DEF_DEPTH,
    parameter int unsigned        STEP     = DEF_STEP,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_address,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               valid,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc
);

    localparam int unsigned       CW     = clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN  = ~(STEP_A - ADDR_W'(1));

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] deliver_pc_q, deliver_pc_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     disc_q, disc_d;

    logic [CW-1:0]     count;
    logic [CW-1:0]     live;
    logic [CW:0]       occupancy;
    logic              issue, retire;
    logic              push, pop, flush;

    if_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH),
        .CNT_W (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (mem_rdata),
        .count (count),
        .head  (instruction)
    );

    // Request gating, issue/retire bookkeeping and redirect handling.
    always_comb begin
        live      = out_q - disc_q;
        occupancy = {1'b0, count} + {1'b0, live};
        mem_req   = !rst && (occupancy < (CW + 1)'(DEPTH)) && (out_q < CW'(DEPTH));
        issue     = mem_req && mem_gnt;
        retire    = mem_rvalid && (out_q != '0);
        valid     = (count != '0);

        out_d        = out_q + CW'(issue) - CW'(retire);
        fetch_pc_d   = issue ? fetch_pc_q + STEP_A : fetch_pc_q;
        deliver_pc_d = deliver_pc_q;
        disc_d       = disc_q;
        flush        = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;

        if (branch_taken) begin
            // Everything still in flight after this edge, including a grant
            // taken right now, belongs to the old path.
            flush        = 1'b1;
            fetch_pc_d   = branch_address & ALIGN;
            deliver_pc_d = branch_address & ALIGN;
            disc_d       = out_d;
        end else begin
            if (retire) begin
                if (disc_q != '0) disc_d = disc_q - CW'(1);
                else              push   = 1'b1;
            end
            pop = valid && !freeze;
            if (pop) deliver_pc_d = deliver_pc_q + STEP_A;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            deliver_pc_q <= RESET_PC;
            out_q        <= '0;
            disc_q       <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            deliver_pc_q <= deliver_pc_d;
            out_q        <= out_d;
            disc_q       <= disc_d;
        end
    end

    assign mem_addr = fetch_pc_q;
    assign pc       = deliver_pc_q + STEP_A;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with an in-order memory responder.
module tb_if_prefetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] pc;

    int          checks = 0;
    int          errors = 0;
    int          grants = 0;
    bit          rsp_en = 1'b0;
    logic [31:0] q [$];

    if_prefetch_stage #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (4),
        .STEP     (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .valid          (valid),
        .instruction    (instruction),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Memory content: tag in the high half, low address bits in the low half.
    function automatic logic [31:0] f(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {16'h0, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record a grant, then present the oldest pending response if enabled.
    task automatic cyc();
        logic        g;
        logic [31:0] a;
        #1;
        g = mem_req && mem_gnt;
        a = mem_addr;
        @(posedge clk);
        #1;
        if (g) begin
            q.push_back(a);
            grants++;
        end
        if (rsp_en && q.size() > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = f(q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        q.delete();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_pc", pc, 32'h4);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        rst = 1'b0;
        #1;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, 32'h0);

        // Zero-wait streaming
        mem_gnt = 1'b1;
        rsp_en  = 1'b1;
        cyc();
        chk("stream_lat_valid", 32'(valid), 32'd0);
        cyc();
        chk("stream0_valid", 32'(valid), 32'd1);
        chk("stream0_pc", pc, 32'h4);
        chk("stream0_instr", instruction, 32'hC0DE_0000);
        cyc();
        chk("stream1_pc", pc, 32'h8);
        chk("stream1_instr", instruction, 32'hC0DE_0004);
        cyc();
        chk("stream2_pc", pc, 32'hC);
        chk("stream2_instr", instruction, 32'hC0DE_0008);

        // Freeze: buffer fills to DEPTH, outputs hold
        freeze = 1'b1;
        do_reset();
        grants = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i == 5 || i == 10) begin
                chk("frz_valid", 32'(valid), 32'd1);
                chk("frz_instr", instruction, 32'hC0DE_0000);
                chk("frz_pc", pc, 32'h4);
            end
        end
        chk("frz_grants", 32'(grants), 32'd4);
        chk("frz_req_off", 32'(mem_req), 32'd0);
        freeze  = 1'b0;
        mem_gnt = 1'b0;
        cyc();
        chk("drain1_instr", instruction, 32'hC0DE_0004);
        chk("drain1_pc", pc, 32'h8);
        cyc();
        chk("drain2_instr", instruction, 32'hC0DE_0008);
        chk("drain2_pc", pc, 32'hC);
        cyc();
        chk("drain3_instr", instruction, 32'hC0DE_000C);
        chk("drain3_pc", pc, 32'h10);
        cyc();
        chk("drain4_valid", 32'(valid), 32'd0);
        chk("drain4_addr", mem_addr, 32'h10);

        // Redirect with two requests in flight
        rsp_en  = 1'b0;
        mem_gnt = 1'b1;
        cyc();
        cyc();
        mem_gnt        = 1'b0;
        branch_taken   = 1'b1;
        branch_address = 32'h103;
        cyc();
        branch_taken = 1'b0;
        chk("br_addr", mem_addr, 32'h100);
        chk("br_valid", 32'(valid), 32'd0);
        chk("br_req", 32'(mem_req), 32'd1);
        rsp_en  = 1'b1;
        mem_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (valid) break;
            cyc();
        end
        chk("br_first_valid", 32'(valid), 32'd1);
        chk("br_first_instr", instruction, 32'hC0DE_0100);
        chk("br_first_pc", pc, 32'h104);

        // Redirect coinciding with a grant and a response
        do_reset();
        rsp_en  = 1'b0;
        mem_gnt = 1'b1;
        cyc();
        mem_rvalid     = 1'b1;
        mem_rdata      = f(q.pop_front());
        branch_taken   = 1'b1;
        branch_address = 32'h200;
        cyc();
        branch_taken = 1'b0;
        chk("brg_valid", 32'(valid), 32'd0);
        chk("brg_addr", mem_addr, 32'h200);
        mem_gnt = 1'b0;
        rsp_en  = 1'b1;
        cyc();
        cyc();
        chk("brg_drop_valid", 32'(valid), 32'd0);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        cyc();
        chk("brg_next_valid", 32'(valid), 32'd1);
        chk("brg_next_instr", instruction, 32'hC0DE_0200);
        chk("brg_next_pc", pc, 32'h204);

        // Reset mid-burst, stray response afterwards
        mem_gnt = 1'b1;
        rsp_en  = 1'b1;
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_pc", pc, 32'h4);
        chk("arst_instr", instruction, 32'h0);
        cyc();
        rst = 1'b0;
        q.delete();
        rsp_en     = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        cyc();
        chk("stray_valid", 32'(valid), 32'd0);
        chk("stray_addr", mem_addr, 32'h0);
        cyc();
        chk("stray_valid2", 32'(valid), 32'd0);

        // Address wrap at the top of the space, with low-bit alignment
        branch_taken   = 1'b1;
        branch_address = 32'hFFFF_FFFE;
        cyc();
        branch_taken = 1'b0;
        chk("wrap_addr_pre", mem_addr, 32'hFFFF_FFFC);
        mem_gnt = 1'b1;
        rsp_en  = 1'b1;
        cyc();
        chk("wrap_addr_post", mem_addr, 32'h0);
        mem_gnt = 1'b0;
        cyc();
        chk("wrap_valid", 32'(valid), 32'd1);
        chk("wrap_instr", instruction, 32'hC0DE_FFFC);
        chk("wrap_pc", pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
